pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//  Consumes ID-stage decode results (RegWEn/WBSel-derived), the EX branch redirect and the data-memory busy flag.
//  Keeps shadow state for EX/MEM/WB occupancy. Drives IF/ID stall, flush, bubble-insert, EX operand-forward selects
//  and a stall-cycle counter.
// PARAMETERS
//  RA_W   5   register-address width (x0..x31)
//  CNT_W  16  width of saturating stall-cycle counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  id_valid     in   1      ID holds a real instruction
//  id_rs1       in   RA_W   ID source 1
//  id_rs2       in   RA_W   ID source 2
//  id_rs1_used  in   1      ID instruction reads rs1
//  id_rs2_used  in   1      ID instruction reads rs2
//  id_rd        in   RA_W   ID destination
//  id_regwen    in   1      ID instruction writes rd
//  id_is_load   in   1      ID instruction is a load (WBSel = mem)
//  ex_redirect  in   1      taken branch/jump resolved in EX (pcSel)
//  mem_busy     in   1      data memory not ready; whole pipe must freeze
//  stall_if     out  1      hold PC
//  stall_id     out  1      hold IF/ID register
//  flush_id     out  1      squash IF/ID register to NOP
//  bubble_ex    out  1      load NOP into ID/EX instead of ID instruction
//  fwd_a_sel    out  2      EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b_sel    out  2      EX operand B source, same encoding
//  stall_cnt    out  CNT_W  cycles lost to data hazards, saturating
// BEHAVIOUR
//  - State: three shadow entries EX, MEM, WB; each {valid, rd, regwen, is_load}; EX also holds rs1/rs2 + used bits.
//  - Reset: all entries invalid, stall_cnt=0; while rst=1 all stall/flush/bubble outputs=0, fwd sels=00.
//  - Priority per cycle: mem_busy > ex_redirect > data hazard > normal advance.
//  - mem_busy=1: stall_if=stall_id=1, flush_id=bubble_ex=0; no entry shifts.
//    ex_redirect is ignored; the producer holds it because EX is frozen. stall_cnt is unchanged.
//  - ex_redirect=1 (not busy): flush_id=1, bubble_ex=1, stall_if=stall_id=0.
//    The EX entry loads invalid. The ID instruction is discarded, giving 2 bubbles. A hazard in the same cycle is ignored.
//  - Data hazard (haz=1): stall_if=stall_id=1, bubble_ex=1; EX loads invalid, MEM/WB shift; stall_cnt+1, saturating at all-ones.
//  - Normal: EX<=ID fields (valid=id_valid), MEM<=EX, WB<=MEM; all control outputs 0.
//  - Match rule: entry valid & regwen & rd!=0 & rd==rs & rs_used. x0 never matches.
//  - Forwarding (EX operands, combinational from state): MEM match -> 01, else WB match -> 10, else 00. MEM wins on a double match.
//  - Regfile is write-first in WB, so ID never hazards against the WB entry.
// CONFIGURATION
//  Macro HAZARD_FORWARDING_EN.
//  - Defined: haz = ID matches EX entry with is_load=1 (load-use) -> exactly 1 stall cycle. Fwd sels as above.
//  - Undefined: fwd_a_sel=fwd_b_sel=00 always; haz = ID matches EX or MEM entry (any regwen).
//    A RAW on the adjacent instruction therefore stalls 2 cycles.
// STRUCTURE
//  - Package rv32_pipe_pkg holds:
//    - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
//    - typedef hz_entry_t {valid, rd, regwen, is_load}
//    - RA_W default
//  - Sub-module hazard_stage_reg: one shadow entry with load/hold/clear control, instantiated 3x.
//  - Match/priority logic stays in the top module.
// TESTING
//  - Reset: hold rst 3 cycles with random inputs -> all outputs 0, stall_cnt=0; first instruction after release advances.
//  - Load-use (FWD_EN): lw x5 then add x6,x5,x7 -> 1 cycle stall_if/stall_id/bubble_ex, then fwd_a_sel=10, stall_cnt=1.
//  - ALU RAW (FWD_EN): add x5 then sub x8,x5,x5 -> no stall, fwd_a_sel=fwd_b_sel=01. Without macro: 2 stall cycles, sels 00.
//  - x0 dest: addi x0 then add x1,x0,x0 -> no stall, fwd sels 00.
//  - Redirect + load-use same cycle -> flush_id=1, bubble_ex=1, stall_if=0, stall_cnt unchanged.
//  - mem_busy 4 cycles during a load-use window -> frozen 4 cycles (stall_cnt unchanged), then the normal 1-cycle load-use stall.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package rv32_pipe_pkg;

   localparam int RA_W_DEF = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                valid;
      logic [RA_W_DEF-1:0] rd;
      logic                regwen;
      logic                is_load;
   } hz_entry_t;

   // EX also remembers its own sources so forwarding can be resolved there
   typedef struct packed {
      hz_entry_t           ent;
      logic [RA_W_DEF-1:0] rs1;
      logic [RA_W_DEF-1:0] rs2;
      logic                rs1_used;
      logic                rs2_used;
   } hz_ex_entry_t;

   // x0 is hardwired zero, so a write to it never creates a dependency
   function automatic logic src_match(hz_entry_t e, logic [RA_W_DEF-1:0] rs, logic used);
      return e.valid & e.regwen & (e.rd != '0) & (e.rd == rs) & used;
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline entry: clear beats load, otherwise hold.
module hazard_stage_reg
   import rv32_pipe_pkg::*;
#(
   parameter type T = hz_entry_t
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic clear_i,
   input  T     d_i,
   output T     q_o
);

   T q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clear_i)     q_d = '0;
      else if (load_i) q_d = d_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble/forward control for the 5-stage RV32 pipe.
// HAZARD_FORWARDING_EN: forward from MEM/WB and stall only on load-use; otherwise stall on any EX/MEM RAW.
module pipeline_hazard_ctrl
   import rv32_pipe_pkg::*;
#(
   parameter int RA_W  = RA_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [RA_W-1:0]  id_rs1_i,
   input  logic [RA_W-1:0]  id_rs2_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [RA_W-1:0]  id_rd_i,
   input  logic             id_regwen_i,
   input  logic             id_is_load_i,
   input  logic             ex_redirect_i,
   input  logic             mem_busy_i,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             flush_id_o,
   output logic             bubble_ex_o,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   hz_ex_entry_t ex_d, ex_q;
   hz_entry_t    mem_q, wb_q;
   logic         busy, redir, hit_ex, hit_mem, haz_raw, haz, ex_clear;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      ex_d             = '0;
      ex_d.ent.valid   = id_valid_i;
      ex_d.ent.rd      = id_rd_i;
      ex_d.ent.regwen  = id_regwen_i;
      ex_d.ent.is_load = id_is_load_i;
      ex_d.rs1         = id_rs1_i;
      ex_d.rs2         = id_rs2_i;
      ex_d.rs1_used    = id_rs1_used_i;
      ex_d.rs2_used    = id_rs2_used_i;
   end

   assign busy    = mem_busy_i;
   assign redir   = ex_redirect_i & ~busy;
   assign hit_ex  = src_match(ex_q.ent, id_rs1_i, id_rs1_used_i) |
                    src_match(ex_q.ent, id_rs2_i, id_rs2_used_i);
   assign hit_mem = src_match(mem_q, id_rs1_i, id_rs1_used_i) |
                    src_match(mem_q, id_rs2_i, id_rs2_used_i);

`ifdef HAZARD_FORWARDING_EN
   assign haz_raw = id_valid_i & hit_ex & ex_q.ent.is_load;
`else
   assign haz_raw = id_valid_i & (hit_ex | hit_mem);
`endif
   // A frozen pipe or a redirect both override a data hazard
   assign haz      = haz_raw & ~busy & ~redir;
   assign ex_clear = redir | haz;

   hazard_stage_reg #(.T(hz_ex_entry_t)) u_ex (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(~busy), .clear_i(ex_clear), .d_i(ex_d), .q_o(ex_q)
   );
   hazard_stage_reg #(.T(hz_entry_t)) u_mem (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(~busy), .clear_i(1'b0), .d_i(ex_q.ent), .q_o(mem_q)
   );
   hazard_stage_reg #(.T(hz_entry_t)) u_wb (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(~busy), .clear_i(1'b0), .d_i(mem_q), .q_o(wb_q)
   );

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (haz && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_if_o  = ~rst_i & (busy | haz);
   assign stall_id_o  = ~rst_i & (busy | haz);
   assign flush_id_o  = ~rst_i & redir;
   assign bubble_ex_o = ~rst_i & (redir | haz);
   assign stall_cnt_o = stall_cnt_q;

`ifdef HAZARD_FORWARDING_EN
   function automatic logic [1:0] fwd_pick(logic [RA_W-1:0] rs, logic used);
      if (src_match(mem_q, rs, used))     return FWD_MEM;
      else if (src_match(wb_q, rs, used)) return FWD_WB;
      else                                return FWD_RF;
   endfunction

   assign fwd_a_sel_o = rst_i ? FWD_RF : fwd_pick(ex_q.rs1, ex_q.rs1_used & ex_q.ent.valid);
   assign fwd_b_sel_o = rst_i ? FWD_RF : fwd_pick(ex_q.rs2, ex_q.rs2_used & ex_q.ent.valid);

   logic unused_bits;
   assign unused_bits = ^{mem_q.is_load, wb_q.is_load};
`else
   assign fwd_a_sel_o = FWD_RF;
   assign fwd_b_sel_o = FWD_RF;

   logic unused_bits;
   assign unused_bits = ^{ex_q.rs1, ex_q.rs2, ex_q.rs1_used, ex_q.rs2_used,
                          ex_q.ent.is_load, mem_q.is_load, wb_q};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARDING_EN.
module tb_pipeline_hazard_ctrl;

   localparam int CW = 3;
`ifdef HAZARD_FORWARDING_EN
   localparam int         LU_ST   = 1;
   localparam int         ALU_ST  = 0;
   localparam logic [1:0] EXP_MEM = 2'b01;
   localparam logic [1:0] EXP_WB  = 2'b10;
`else
   localparam int         LU_ST   = 2;
   localparam int         ALU_ST  = 2;
   localparam logic [1:0] EXP_MEM = 2'b00;
   localparam logic [1:0] EXP_WB  = 2'b00;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic          id_valid, id_rs1_used, id_rs2_used, id_regwen, id_is_load;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic          ex_redirect = 1'b0, mem_busy = 1'b0;
   logic          stall_if, stall_id, flush_id, bubble_ex;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_cnt;

   int            ntests = 0, nfail = 0;
   logic [CW-1:0] exp_cnt = '0;

   pipeline_hazard_ctrl #(.RA_W(5), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
      .id_regwen_i(id_regwen), .id_is_load_i(id_is_load), .ex_redirect_i(ex_redirect),
      .mem_busy_i(mem_busy), .stall_if_o(stall_if), .stall_id_o(stall_id), .flush_id_o(flush_id),
      .bubble_ex_o(bubble_ex), .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel), .stall_cnt_o(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] rd, rs1, rs2,
                        input logic u1, u2, wen, ld);
      id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_rs1_used = u1; id_rs2_used = u2; id_regwen = wen; id_is_load = ld;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rnd_in();
      drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      ex_redirect = 1'($urandom);
      mem_busy    = 1'($urandom);
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic bump();
      if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
   endtask

   // Samples mid-cycle, then consumes the clock edge
   task automatic chk(input string tag, input logic s, f, b,
                      input logic [1:0] fa, fb, input logic [CW-1:0] c);
      logic [CW+7:0] got, want;
      #3;
      got  = {stall_if, stall_id, flush_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_cnt};
      want = {s, s, f, b, fa, fb, c};
      ntests++;
      assert (got === want) else begin
         nfail++;
         $error("FAIL %s got=%b want=%b (if,id,flush,bubble,fa,fb,cnt)", tag, got, want);
      end
      cyc();
   endtask

   // lw x5 followed by add x6,x5,x7, optionally frozen by mem_busy first
   task automatic lu_seq(input int nbusy);
      drive(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("lu_lw", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < nbusy; i++) begin
         mem_busy    = 1'b1;
         ex_redirect = (i == 1);
         chk("busy_freeze", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      end
      mem_busy = 1'b0; ex_redirect = 1'b0;
      for (int i = 0; i < LU_ST; i++) begin
         chk("lu_stall", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, exp_cnt);
         bump();
      end
      chk("lu_go", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      idle();
      chk("lu_fwd", 1'b0, 1'b0, 1'b0, EXP_WB, 2'b00, exp_cnt);
      cyc(); cyc();
   endtask

   initial begin
      rnd_in();
      cyc();
      for (int i = 0; i < 3; i++) begin
         rnd_in();
         chk("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0);
      end
      rst = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;

      // add x5,x1,x2 ; sub x8,x5,x5
      drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("first_adv", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      drive(1'b1, 5'd8, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < ALU_ST; i++) begin
         chk("alu_stall", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, exp_cnt);
         bump();
      end
      chk("alu_go", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      idle();
      chk("alu_fwd", 1'b0, 1'b0, 1'b0, EXP_MEM, EXP_MEM, exp_cnt);
      cyc(); cyc();

      // addi x0,x1,0 ; add x1,x0,x0
      drive(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("x0_a", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("x0_b", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      idle();
      chk("x0_fwd", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      cyc(); cyc();

      // redirect coinciding with a load-use pair
      drive(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("redir_lw", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      ex_redirect = 1'b1;
      chk("redir", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, exp_cnt);
      ex_redirect = 1'b0;
      idle();
      chk("redir_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, exp_cnt);
      cyc(); cyc();

      lu_seq(0);
      lu_seq(4);
      for (int k = 0; k < 6; k++) lu_seq(0);
      chk("sat_final", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, {CW{1'b1}});

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
